// File: rtl/mac_operand_loader.sv
// Pairs host strobe bytes into (A,B) operands, queues them in a show-ahead FIFO and
// issues them to the MAC over valid/ready; also sequences host CLEAR/ERRCLR commands.
module mac_operand_loader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_strobe,
    input  logic             in_mode,
    output logic [WIDTH-1:0] mac_a,
    output logic [WIDTH-1:0] mac_b,
    output logic             mac_valid,
    input  logic             mac_ready,
    output logic             mac_clr,
    output logic             busy,
    output logic             full,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] CMD_CLEAR  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CMD_ERRCLR = WIDTH'(2);

    typedef enum logic [1:0] {
        WAIT_A,
        WAIT_B,
        CLR_WAIT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_hold;

    logic strb_s1, strb_s2, strb_s3, byte_evt;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    logic empty, full_int, pop, op_evt, cmd_evt, push_req, push, overflow;

    // Strobe is asynchronous: two flops to resolve metastability, a third for the
    // edge history; byte_evt is registered so it lands on the third clk edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_s1  <= 1'b0;
            strb_s2  <= 1'b0;
            strb_s3  <= 1'b0;
            byte_evt <= 1'b0;
        end else begin
            strb_s1  <= in_strobe;
            strb_s2  <= strb_s1;
            strb_s3  <= strb_s2;
            byte_evt <= strb_s2 & ~strb_s3;
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full_int = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = ~empty & mac_ready;

    assign op_evt   = byte_evt & ~in_mode;
    assign cmd_evt  = byte_evt & in_mode;
    assign push_req = (state == WAIT_B) && op_evt;
    // A full FIFO still accepts the pair when the head leaves in the same cycle.
    assign push     = push_req && (!full_int || pop);
    assign overflow = push_req && full_int && !pop;

    // NOTE: the storage array is reset too, so mac_a/mac_b read 0 the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_a[wr_ptr[AW-1:0]] <= a_hold;
                mem_b[wr_ptr[AW-1:0]] <= in_data;
                wr_ptr                <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_A;
            a_hold   <= '0;
            err      <= 1'b0;
            mac_clr  <= 1'b0;
            op_count <= '0;
        end else begin
            mac_clr <= 1'b0;
            if (pop && (op_count != {CNT_W{1'b1}})) begin
                op_count <= op_count + CNT_W'(1);
            end

            if (state == CLR_WAIT) begin
                // Empty implies nothing in flight, so the clear lands after the last pop.
                if (empty) begin
                    mac_clr  <= 1'b1;
                    op_count <= '0;
                    state    <= WAIT_A;
                end
            end else if (cmd_evt) begin
                if (in_data == CMD_CLEAR) begin
                    a_hold <= '0;
                    state  <= CLR_WAIT;
                end else if (in_data == CMD_ERRCLR) begin
                    err   <= 1'b0;
                    state <= WAIT_A;
                end
            end else if (op_evt) begin
                if (state == WAIT_A) begin
                    a_hold <= in_data;
                    state  <= WAIT_B;
                end else begin
                    if (overflow) begin
                        err <= 1'b1;
                    end
                    state <= WAIT_A;
                end
            end
        end
    end

    assign mac_valid = ~empty;
    assign mac_a     = mem_a[rd_ptr[AW-1:0]];
    assign mac_b     = mem_b[rd_ptr[AW-1:0]];
    assign full      = full_int;
    assign busy      = (state != WAIT_A) || ~empty;

endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed bench for mac_operand_loader: pairing, overflow, CLEAR/ERRCLR sequencing,
// full-FIFO push/pop overlap and asynchronous reset.
module tb_mac_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_strobe = 1'b0;
    logic       in_mode = 1'b0;
    logic [7:0] mac_a, mac_b;
    logic       mac_valid;
    logic       mac_ready = 1'b0;
    logic       mac_clr, busy, full, err;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    mac_operand_loader #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_strobe (in_strobe),
        .in_mode   (in_mode),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_valid (mac_valid),
        .mac_ready (mac_ready),
        .mac_clr   (mac_clr),
        .busy      (busy),
        .full      (full),
        .err       (err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mac_clr) begin
            clr_cnt++;
            check("clr_with_valid", {31'd0, mac_valid}, 32'd0);
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in_strobe = 1'b0;
        mac_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic mode, input logic [7:0] d);
        in_data   = d;
        in_mode   = mode;
        in_strobe = 1'b1;
        repeat (6) @(negedge clk);
        in_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        send_byte(1'b0, a);
        send_byte(1'b0, b);
    endtask

    // Raises ready and compares every presented pair against the expected queues.
    task automatic drain(input string tag);
        int got = 0;
        int n_exp = exp_a.size();
        mac_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (mac_valid) begin
                if (got < n_exp) begin
                    check({tag, "_a"}, mac_a, exp_a[got]);
                    check({tag, "_b"}, mac_b, exp_b[got]);
                end
                got++;
            end
            @(negedge clk);
        end
        mac_ready = 1'b0;
        check({tag, "_count"}, got, n_exp);
        exp_a.delete();
        exp_b.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", mac_valid, 0);
        check("rst_a", mac_a, 0);
        check("rst_b", mac_b, 0);
        check("rst_clr", mac_clr, 0);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_count", op_count, 0);

        // 1: single pair with exact latency, one-cycle valid pulse under ready=1
        mac_ready = 1'b1;
        send_byte(1'b0, 8'h03);
        in_data   = 8'h05;
        in_mode   = 1'b0;
        in_strobe = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_valid_early", mac_valid, 0);
        @(negedge clk);
        check("t1_valid", mac_valid, 1);
        check("t1_a", mac_a, 8'h03);
        check("t1_b", mac_b, 8'h05);
        @(negedge clk);
        check("t1_valid_pulse", mac_valid, 0);
        check("t1_count", op_count, 1);
        repeat (1) @(negedge clk);
        in_strobe = 1'b0;
        repeat (4) @(negedge clk);
        mac_ready = 1'b0;

        // 2: overflow with ready low, then in-order drain of the 4 survivors
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_pair(8'(8'h10 + i), 8'(8'h20 + i));
            exp_a.push_back(8'(8'h10 + i));
            exp_b.push_back(8'(8'h20 + i));
        end
        check("t2_full", full, 1);
        check("t2_err_before", err, 0);
        send_pair(8'h1f, 8'h2f);
        check("t2_err", err, 1);
        check("t2_full_after", full, 1);
        drain("t2");
        check("t2_count", op_count, 4);
        check("t2_not_full", full, 0);

        // 3: CLEAR waits for the queue to drain, bytes meanwhile are ignored
        do_reset();
        send_pair(8'h31, 8'h32);
        send_pair(8'h41, 8'h42);
        clr_cnt = 0;
        send_byte(1'b1, 8'h01);
        send_byte(1'b0, 8'h77);
        send_byte(1'b0, 8'h78);
        check("t3_no_clr", clr_cnt, 0);
        check("t3_busy", busy, 1);
        check("t3_head_a", mac_a, 8'h31);
        mac_ready = 1'b1;
        @(negedge clk);
        check("t3_second_valid", mac_valid, 1);
        check("t3_second_a", mac_a, 8'h41);
        @(negedge clk);
        check("t3_empty", mac_valid, 0);
        check("t3_count2", op_count, 2);
        check("t3_clr_not_yet", mac_clr, 0);
        @(negedge clk);
        check("t3_clr", mac_clr, 1);
        check("t3_count0", op_count, 0);
        @(negedge clk);
        check("t3_clr_pulse", mac_clr, 0);
        check("t3_idle", busy, 0);
        mac_ready = 1'b0;
        check("t3_clr_total", clr_cnt, 1);
        send_pair(8'h33, 8'h44);
        check("t3_post_valid", mac_valid, 1);
        check("t3_post_a", mac_a, 8'h33);
        check("t3_post_b", mac_b, 8'h44);

        // 4: ERRCLR in WAIT_B clears err and drops the partial operand
        do_reset();
        for (int i = 0; i < 5; i++) send_pair(8'(i), 8'(i + 8));
        check("t4_err_set", err, 1);
        mac_ready = 1'b1;
        repeat (8) @(negedge clk);
        mac_ready = 1'b0;
        check("t4_drained", mac_valid, 0);
        check("t4_err_sticky", err, 1);
        send_byte(1'b0, 8'h99);
        check("t4_wait_b", busy, 1);
        send_byte(1'b1, 8'h02);
        check("t4_err_clr", err, 0);
        check("t4_idle", busy, 0);
        send_pair(8'h11, 8'h22);
        check("t4_valid", mac_valid, 1);
        check("t4_a", mac_a, 8'h11);
        check("t4_b", mac_b, 8'h22);

        // 5: push into a full FIFO in the same cycle as a pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_pair(8'(8'h50 + i), 8'(8'h60 + i));
            if (i > 0) begin
                exp_a.push_back(8'(8'h50 + i));
                exp_b.push_back(8'(8'h60 + i));
            end
        end
        exp_a.push_back(8'h5a);
        exp_b.push_back(8'h6a);
        send_byte(1'b0, 8'h5a);
        in_data   = 8'h6a;
        in_mode   = 1'b0;
        in_strobe = 1'b1;
        repeat (3) @(negedge clk);
        mac_ready = 1'b1;
        @(negedge clk);
        mac_ready = 1'b0;
        check("t5_full", full, 1);
        check("t5_no_err", err, 0);
        check("t5_count", op_count, 1);
        check("t5_head", mac_a, 8'h51);
        repeat (2) @(negedge clk);
        in_strobe = 1'b0;
        repeat (4) @(negedge clk);
        drain("t5");

        // 6: asynchronous reset mid-stream clears outputs before the next edge
        do_reset();
        for (int i = 0; i < 5; i++) send_pair(8'(8'h70 + i), 8'(8'h80 + i));
        check("t6_pre_valid", mac_valid, 1);
        check("t6_pre_err", err, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", mac_valid, 0);
        check("t6_a", mac_a, 0);
        check("t6_b", mac_b, 0);
        check("t6_full", full, 0);
        check("t6_busy", busy, 0);
        check("t6_err", err, 0);
        check("t6_count", op_count, 0);
        check("t6_clr", mac_clr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pair(8'h0a, 8'h0b);
        check("t6_new_valid", mac_valid, 1);
        check("t6_new_a", mac_a, 8'h0a);
        check("t6_new_b", mac_b, 8'h0b);
        mac_ready = 1'b1;
        @(negedge clk);
        mac_ready = 1'b0;
        check("t6_new_count", op_count, 1);
        check("t6_new_empty", mac_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
